// File: rtl/avmm_led_out_pio.sv
// Avalon-MM output PIO driving LED pins from a writable data register, with
// atomic set/clear strobes and a free-running blink engine.
module avmm_led_out_pio #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned RESET_PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink_en;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;
  logic [31:0]         r_readdata;

  logic                w_wr;
  logic [WIDTH-1:0]    w_wdata;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  // Upper writedata bits beyond WIDTH/PERIOD_W are deliberately ignored.
  assign w_unused = &{1'b0, writedata};

  // Data register: plain load plus atomic set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= WIDTH'(RESET_VALUE);
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data <= w_wdata;
        ADDR_OUTSET:   r_data <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
        default:       r_data <= r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_en <= '0;
      r_period   <= PERIOD_W'(RESET_PERIOD);
    end else if (w_wr) begin
      if (address == ADDR_BLINK_EN) r_blink_en <= w_wdata;
      if (address == ADDR_PERIOD)   r_period   <= writedata[PERIOD_W-1:0];
    end
  end

  // Blink engine: a PERIOD write restarts the half-period from phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr && (address == ADDR_PERIOD)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_period) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PERIOD_W'(1);
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      ADDR_DATA:     w_rd_mux = 32'(r_data);
      ADDR_BLINK_EN: w_rd_mux = 32'(r_blink_en);
      ADDR_PERIOD:   w_rd_mux = 32'(r_period);
      default:       w_rd_mux = 32'd0;
    endcase
  end

  // Read data is captured every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= 32'd0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign out_port = r_data ^ (r_blink_en & {WIDTH{r_phase}});

endmodule

// File: tb/tb_avmm_led_out_pio.sv
// Directed bench for avmm_led_out_pio: register-map vector table plus
// hand-built blink, terminal-count and reset sequences.
module tb_avmm_led_out_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int n_vec;
  int n_bad;

  avmm_led_out_pio #(
    .WIDTH(4), .RESET_VALUE(10), .PERIOD_W(24), .RESET_PERIOD(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // cs, wn, addr, wdata, exp_out, exp_rd (readdata shows pre-edge register value)
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h5,        4'h5, 32'hA};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h5, 32'h5};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h8,        4'hD, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h1,        4'hC, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 3'd0, 32'h0,        4'hC, 32'hC};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 32'hFFFFFFFF, 4'hC, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'd6, 32'hFFFFFFFF, 4'hC, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd7, 32'hFFFFFFFF, 4'hC, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 32'h0,        4'hC, 32'hC};
    vecs[9]  = '{1'b0, 1'b0, 3'd4, 32'h3,        4'hC, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 3'd1, 32'hF,        4'hC, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 3'd1, 32'h0,        4'hC, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 32'h0,        4'hC, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 3'd0, 32'h0,        4'hC, 32'hC};
    vecs[14] = '{1'b1, 1'b0, 3'd1, 32'hF,        4'hC, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 3'd1, 32'h0,        4'hC, 32'hF};
    vecs[16] = '{1'b1, 1'b0, 3'd1, 32'h0,        4'hC, 32'hF};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 32'hC};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;

    #22;
    check("reset_out", 32'(out_port), 32'hA);
    check("reset_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycle();
    check("post_reset_rd_data", readdata, 32'hA);

    for (int i = 0; i < 18; i++) begin
      bus_cycle(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // Blink bit 0 with half-period of 4 cycles.
    bus_cycle(1'b1, 1'b0, 3'd1, 32'h1);
    check("blink_en_set_out", 32'(out_port), 32'h0);
    bus_cycle(1'b1, 1'b0, 3'd2, 32'd3);
    for (int k = 0; k < 16; k++) begin
      if (k != 0) idle_cycle();
      check($sformatf("blink_k%0d", k), 32'(out_port), 32'((k / 4) % 2));
    end

    // PERIOD rewrite while phase=1 on a terminal-count cycle: write wins.
    bus_cycle(1'b1, 1'b0, 3'd2, 32'd3);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) idle_cycle();
      check($sformatf("restart_k%0d", k), 32'(out_port), 32'((k / 4) % 2));
    end

    // PERIOD=0 while phase=1 halts blinking at the DATA value.
    bus_cycle(1'b1, 1'b0, 3'd2, 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) idle_cycle();
      check($sformatf("halt_k%0d", k), 32'(out_port), 32'h0);
    end

    // DATA write coinciding with a phase 0->1 terminal count.
    bus_cycle(1'b1, 1'b0, 3'd1, 32'hF);
    check("tc_en_out", 32'(out_port), 32'h0);
    bus_cycle(1'b1, 1'b0, 3'd2, 32'd2);
    check("tc_e0", 32'(out_port), 32'h0);
    idle_cycle();
    check("tc_e1", 32'(out_port), 32'h0);
    idle_cycle();
    check("tc_e2", 32'(out_port), 32'h0);
    bus_cycle(1'b1, 1'b0, 3'd0, 32'h3);
    check("tc_data_write", 32'(out_port), 32'hC);
    idle_cycle();
    check("tc_e4", 32'(out_port), 32'hC);
    idle_cycle();
    check("tc_e5", 32'(out_port), 32'hC);
    idle_cycle();
    check("tc_e6", 32'(out_port), 32'h3);
    bus_cycle(1'b1, 1'b1, 3'd2, 32'h0);
    check("tc_period_rd", readdata, 32'h2);

    // Asynchronous reset mid-blink.
    #3;
    reset_n = 1'b0;
    #1;
    check("midblink_reset_out", 32'(out_port), 32'hA);
    check("midblink_reset_rd", readdata, 32'h0);
    idle_cycle();
    check("reset_held_out", 32'(out_port), 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
